// File: rtl/fe_sq_arbiter.sv
// Round-robin arbiter that shares one fe_sq squaring unit among NREQ requesters.
// Drives the unit's start/done handshake and returns the result with a one-cycle ack.
module fe_sq_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 320,
  parameter int unsigned IDW  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_f,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      res,
  output logic [IDW-1:0]    res_id,
  output logic              busy,
  output logic              sq_start,
  output logic [W-1:0]      sq_f,
  input  logic [W-1:0]      sq_h,
  input  logic              sq_done
);

  typedef enum logic [1:0] {StIdle, StIssue, StRelease} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic [W-1:0]    f_q, f_d;
  logic [W-1:0]    res_q, res_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            start_q, start_d;

  logic            pick_valid;
  logic [IDW-1:0]  pick_idx;
  logic [W-1:0]    pick_f;

  // Lowest set index above last wins; otherwise wrap to the lowest index at or below last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_f     = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req[i] && (IDW'(i) <= last_q)) begin
        pick_valid = 1'b1;
        pick_idx   = IDW'(i);
        pick_f     = req_f[i*W +: W];
      end
    end
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req[i] && (IDW'(i) > last_q)) begin
        pick_valid = 1'b1;
        pick_idx   = IDW'(i);
        pick_f     = req_f[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    f_d      = f_q;
    start_d  = start_q;
    ack_d    = '0;
    res_d    = res_q;
    res_id_d = res_id_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          f_d     = pick_f;
          gnt_d   = pick_idx;
          last_d  = pick_idx;
          start_d = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (sq_done) begin
          res_d    = sq_h;
          res_id_d = gnt_q;
          ack_d    = NREQ'(1) << gnt_q;
          start_d  = 1'b0;
          state_d  = StRelease;
        end
      end
      StRelease: begin
        // Hold off the next grant until the unit has dropped its done.
        if (!sq_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      last_q   <= IDW'(NREQ - 1);
      gnt_q    <= '0;
      f_q      <= '0;
      start_q  <= 1'b0;
      ack_q    <= '0;
      res_q    <= '0;
      res_id_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      f_q      <= f_d;
      start_q  <= start_d;
      ack_q    <= ack_d;
      res_q    <= res_d;
      res_id_q <= res_id_d;
    end
  end

  assign ack      = ack_q;
  assign res      = res_q;
  assign res_id   = res_id_q;
  assign sq_start = start_q;
  assign sq_f     = f_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_fe_sq_arbiter.sv
// Directed bench for fe_sq_arbiter with a behavioural squaring unit of fixed latency
// and configurable done-hold after start falls.
module tb_fe_sq_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 320;
  localparam int unsigned IDW  = 3;
  localparam int          L_SQ = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_f;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      res;
  logic [IDW-1:0]    res_id;
  logic              busy;
  logic              sq_start;
  logic [W-1:0]      sq_f;
  logic [W-1:0]      sq_h;
  logic              sq_done;

  int n_cmp = 0;
  int n_bad = 0;
  int done_hold = 1;
  int sq_cnt, sq_hold;
  int cyc_cnt = 0;
  int stale_viol = 0;
  logic start_prev = 1'b0;

  fe_sq_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_f    (req_f),
    .ack      (ack),
    .res      (res),
    .res_id   (res_id),
    .busy     (busy),
    .sq_start (sq_start),
    .sq_f     (sq_f),
    .sq_h     (sq_h),
    .sq_done  (sq_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Squaring unit: done rises L_SQ cycles after start; drops done_hold edges after start falls.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sq_cnt  <= 0;
      sq_hold <= 0;
      sq_done <= 1'b0;
      sq_h    <= '0;
    end else if (sq_start) begin
      sq_hold <= 0;
      if (!sq_done) begin
        if (sq_cnt == L_SQ - 1) begin
          sq_done <= 1'b1;
          sq_h    <= W'(64'(sq_f[31:0]) * 64'(sq_f[31:0]));
          sq_cnt  <= 0;
        end else begin
          sq_cnt <= sq_cnt + 1;
        end
      end
    end else begin
      sq_cnt <= 0;
      if (sq_done) begin
        if (sq_hold >= done_hold - 1) begin
          sq_done <= 1'b0;
          sq_hold <= 0;
        end else begin
          sq_hold <= sq_hold + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (sq_start && !start_prev && sq_done) stale_viol <= stale_viol + 1;
    start_prev <= sq_start;
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_f(input int i, input logic [31:0] v);
    req_f[i*W +: W] = W'(v);
  endtask

  task automatic wait_ack(input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL ack_timeout: got no ack within %0d cycles", budget);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || sq_done) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("idle", W'(busy), '0);
  endtask

  task automatic check_rst(input string tag);
    check_eq({tag, "_ack"}, W'(ack), '0);
    check_eq({tag, "_res"}, res, '0);
    check_eq({tag, "_res_id"}, W'(res_id), '0);
    check_eq({tag, "_busy"}, W'(busy), '0);
    check_eq({tag, "_sq_start"}, W'(sq_start), '0);
    check_eq({tag, "_sq_f"}, sq_f, '0);
  endtask

  int cyc, k, stray;
  int t_ack[5];
  int id_exp;

  initial begin
    reset = 1'b0;
    req   = '0;
    req_f = '0;
    repeat (2) @(negedge clk);
    check_rst("rst");
    reset = 1'b1;

    // Single request from requester 0.
    set_f(0, 3);
    req = 4'b0001;
    wait_ack(20, cyc);
    check_eq("t1_lat", W'(cyc), W'(L_SQ + 2));
    check_eq("t1_ack", W'(ack), W'(4'b0001));
    check_eq("t1_res", res, W'(9));
    check_eq("t1_id", W'(res_id), W'(0));
    req = '0;
    @(negedge clk);
    check_eq("t1_ack_width", W'(ack), '0);
    k = 1;
    while (busy && k < 5) begin
      @(negedge clk);
      k++;
    end
    check_eq("t1_busy_lo", W'(busy), '0);
    check_eq("t1_busy_dly", W'(k >= 1 && k <= 3), W'(1));
    wait_idle();

    // All four requesting from reset priority.
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 4; i++) set_f(i, 32'(i + 1));
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ack(30, cyc);
      t_ack[n] = cyc_cnt;
      id_exp = n % 4;
      check_eq($sformatf("t2_ack%0d", n), W'(ack), W'(4'b0001 << id_exp));
      check_eq($sformatf("t2_res%0d", n), res, W'((id_exp + 1) * (id_exp + 1)));
      check_eq($sformatf("t2_id%0d", n), W'(res_id), W'(id_exp));
      @(negedge clk);
      check_eq($sformatf("t2_ackw%0d", n), W'(ack), '0);
    end
    check_eq("t2_gap", W'(t_ack[1] - t_ack[0]), W'(L_SQ + 4));
    req = '0;
    wait_idle();

    // Done lingers after start falls; next operation must not complete on the stale done.
    done_hold = 3;
    set_f(1, 6);
    req = 4'b0010;
    wait_ack(30, cyc);
    check_eq("t3_ack1", W'(ack), W'(4'b0010));
    check_eq("t3_res1", res, W'(36));
    set_f(1, 7);
    wait_ack(40, cyc);
    check_eq("t3_ack2", W'(ack), W'(4'b0010));
    check_eq("t3_res2", res, W'(49));
    check_eq("t3_stale", W'(stale_viol), '0);
    req = '0;
    wait_idle();
    done_hold = 1;

    // Operand changes after the grant edge.
    set_f(2, 5);
    req = 4'b0100;
    @(negedge clk);
    set_f(2, 7);
    wait_ack(30, cyc);
    check_eq("t4_ack", W'(ack), W'(4'b0100));
    check_eq("t4_res", res, W'(25));
    check_eq("t4_id", W'(res_id), W'(2));
    req = '0;
    wait_idle();

    // Reset in the middle of an operation.
    set_f(0, 9);
    req = 4'b0001;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_rst("t5");
    req = 4'b1000;
    set_f(3, 0);
    @(negedge clk) reset = 1'b1;
    wait_ack(30, cyc);
    check_eq("t5_ack", W'(ack), W'(4'b1000));
    check_eq("t5_res", res, '0);
    check_eq("t5_id", W'(res_id), W'(3));
    req = '0;
    wait_idle();

    // Requester 1 pulses and withdraws while requester 0 is in flight.
    set_f(0, 2);
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0011;
    repeat (2) @(negedge clk);
    req = 4'b0001;
    wait_ack(30, cyc);
    check_eq("t6_ack", W'(ack), W'(4'b0001));
    check_eq("t6_res", res, W'(4));
    req = '0;
    stray = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ack != '0) stray++;
    end
    check_eq("t6_no_ack1", W'(stray), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
